// File: rtl/cpe_column_ctrl.sv
// cpe_column_ctrl: sequencer for one column of ROWS chained compensation PEs.
// Preloads 4-bit compensation weights down the CPE weight-pass chain (bottom row
// first), streams activation vectors with a one-cycle-per-row valid skew, and
// flags the cycles where the bottom row's compensation output is a finished sum.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start/num_vec/cw_base job launch (sampled only in IDLE)
//   busy, done           job status (done is a one-cycle pulse)
//   cw_rd_en/cw_addr     compensation-memory read port, cw_rdata returned 1 cycle later
//   cw_data/cw_valid     weight into row 0 of the chain and chain shift enable
//   act_rd_en/act_addr   activation-buffer read port (address = vector index)
//   act_valid[ROWS]      per-row skewed activation valid
//   out_valid/out_idx    bottom-row finished sum and its vector index
//
// Optional macro CPE_CTRL_PERF_EN adds saturating perf_cycles/perf_jobs counters.
module cpe_column_ctrl #(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned CW_AW  = 6,
    parameter int unsigned ACT_AW = 8,
    parameter int unsigned NV_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NV_W-1:0]   num_vec,
    input  logic [CW_AW-1:0]  cw_base,
    output logic              busy,
    output logic              done,
    output logic              cw_rd_en,
    output logic [CW_AW-1:0]  cw_addr,
    input  logic [3:0]        cw_rdata,
    output logic [3:0]        cw_data,
    output logic              cw_valid,
    output logic              act_rd_en,
    output logic [ACT_AW-1:0] act_addr,
    output logic [ROWS-1:0]   act_valid,
    output logic              out_valid,
    output logic [NV_W-1:0]   out_idx
`ifdef CPE_CTRL_PERF_EN
    ,
    output logic [15:0]       perf_cycles,
    output logic [15:0]       perf_jobs
`endif
);

    localparam int unsigned CLOG_R = $clog2(ROWS + 1);
    localparam int unsigned CNT_W  = (NV_W > CLOG_R) ? NV_W : CLOG_R;
    localparam logic [CW_AW-1:0] LAST_ROW = CW_AW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NV_W-1:0]    nv_q, nv_d;
    logic [CW_AW-1:0]   base_q, base_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cw_rd_en_q, cw_rd_en_d;
    logic [CW_AW-1:0]   cw_addr_q, cw_addr_d;
    logic               cw_valid_q;
    logic               act_rd_en_q, act_rd_en_d;
    logic [ACT_AW-1:0]  act_addr_q, act_addr_d;
    logic [ROWS-1:0]    skew_q;
    logic               out_valid_q;
    logic [NV_W-1:0]    out_idx_q, out_idx_d;
    logic               last_read;

    // Final activation read of the job is issued in this STREAM cycle
    assign last_read = (cnt_q == (CNT_W'(nv_q) - CNT_W'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nv_q    <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nv_q    <= nv_d;
            base_q  <= base_d;
        end
    end

    // Next-state logic; cnt_q counts cycles within the current phase
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nv_d    = nv_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_W;
                    cnt_d   = '0;
                    nv_d    = num_vec;
                    base_d  = cw_base;
                end
            end
            LOAD_W: begin
                // ROWS read cycles plus one cycle for the last read data to land
                if (cnt_q == CNT_W'(ROWS)) begin
                    cnt_d   = '0;
                    state_d = (nv_q == '0) ? DRAIN : STREAM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STREAM: begin
                if (last_read) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (done_q) begin
                    state_d = IDLE;
                end else if (cnt_q != CNT_W'(ROWS)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        cw_rd_en_d  = 1'b0;
        cw_addr_d   = cw_addr_q;
        act_rd_en_d = 1'b0;
        act_addr_d  = act_addr_q;
        done_d      = 1'b0;
        out_idx_d   = out_valid_q ? (out_idx_q + NV_W'(1)) : out_idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Bottom row's weight goes first so it ends deepest in the chain
                    cw_rd_en_d = 1'b1;
                    cw_addr_d  = cw_base + LAST_ROW;
                    out_idx_d  = '0;
                end
            end
            LOAD_W: begin
                if (cnt_q < CNT_W'(ROWS - 1)) begin
                    cw_rd_en_d = 1'b1;
                    cw_addr_d  = cw_addr_q - CW_AW'(1);
                end else if (cnt_q == CNT_W'(ROWS)) begin
                    if (nv_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        act_rd_en_d = 1'b1;
                        act_addr_d  = '0;
                    end
                end
            end
            STREAM: begin
                if (!last_read) begin
                    act_rd_en_d = 1'b1;
                    act_addr_d  = act_addr_q + ACT_AW'(1);
                end
            end
            DRAIN: begin
                // Last out_valid is ROWS+1 cycles after the final read
                done_d = !done_q && (cnt_q == CNT_W'(ROWS));
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Output registers and the row-skew shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cw_rd_en_q  <= 1'b0;
            cw_addr_q   <= '0;
            cw_valid_q  <= 1'b0;
            act_rd_en_q <= 1'b0;
            act_addr_q  <= '0;
            skew_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            cw_rd_en_q  <= cw_rd_en_d;
            cw_addr_q   <= cw_addr_d;
            cw_valid_q  <= cw_rd_en_q;
            act_rd_en_q <= act_rd_en_d;
            act_addr_q  <= act_addr_d;
            skew_q      <= {skew_q[ROWS-2:0], act_rd_en_q};
            out_valid_q <= skew_q[ROWS-1];
            out_idx_q   <= out_idx_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cw_rd_en  = cw_rd_en_q;
    assign cw_addr   = cw_addr_q;
    assign cw_data   = cw_rdata;
    assign cw_valid  = cw_valid_q;
    assign act_rd_en = act_rd_en_q;
    assign act_addr  = act_addr_q;
    assign act_valid = skew_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;

`ifdef CPE_CTRL_PERF_EN
    logic [15:0] perf_cycles_q;
    logic [15:0] perf_jobs_q;

    // Saturating busy-cycle and completed-job counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_jobs_q   <= '0;
        end else begin
            if (busy_q && (perf_cycles_q != 16'hFFFF)) perf_cycles_q <= perf_cycles_q + 16'd1;
            if (done_q && (perf_jobs_q != 16'hFFFF))   perf_jobs_q   <= perf_jobs_q + 16'd1;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_jobs   = perf_jobs_q;
`endif

endmodule

// File: tb/tb_cpe_column_ctrl.sv
// Testbench for cpe_column_ctrl (ROWS=4): directed and randomized jobs checked
// cycle-by-cycle against timing windows derived from the job parameters, plus a
// compensation memory model and a weight-chain model.
module tb_cpe_column_ctrl;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned CW_AW  = 6;
    localparam int unsigned ACT_AW = 8;
    localparam int unsigned NV_W   = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [NV_W-1:0]   num_vec;
    logic [CW_AW-1:0]  cw_base;
    logic              busy;
    logic              done;
    logic              cw_rd_en;
    logic [CW_AW-1:0]  cw_addr;
    logic [3:0]        cw_rdata;
    logic [3:0]        cw_data;
    logic              cw_valid;
    logic              act_rd_en;
    logic [ACT_AW-1:0] act_addr;
    logic [ROWS-1:0]   act_valid;
    logic              out_valid;
    logic [NV_W-1:0]   out_idx;
`ifdef CPE_CTRL_PERF_EN
    logic [15:0]       perf_cycles;
    logic [15:0]       perf_jobs;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [3:0] mem   [64];
    logic [3:0] chain [ROWS];

    cpe_column_ctrl #(
        .ROWS(ROWS), .CW_AW(CW_AW), .ACT_AW(ACT_AW), .NV_W(NV_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec), .cw_base(cw_base),
        .busy(busy), .done(done), .cw_rd_en(cw_rd_en), .cw_addr(cw_addr),
        .cw_rdata(cw_rdata), .cw_data(cw_data), .cw_valid(cw_valid),
        .act_rd_en(act_rd_en), .act_addr(act_addr), .act_valid(act_valid),
        .out_valid(out_valid), .out_idx(out_idx)
`ifdef CPE_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_jobs(perf_jobs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compensation memory: one-cycle read latency
    always @(posedge clk) if (cw_rd_en === 1'b1) cw_rdata <= mem[cw_addr];

    // CPE weight-pass chain: row 0 takes cw_data, each row passes down
    always @(posedge clk) begin
        if (cw_valid === 1'b1) begin
            for (int r = ROWS - 1; r > 0; r--) chain[r] <= chain[r-1];
            chain[0] <= cw_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_busy"},      64'(busy),      64'(0));
        chk({pfx, "_done"},      64'(done),      64'(0));
        chk({pfx, "_cw_rd_en"},  64'(cw_rd_en),  64'(0));
        chk({pfx, "_cw_addr"},   64'(cw_addr),   64'(0));
        chk({pfx, "_cw_valid"},  64'(cw_valid),  64'(0));
        chk({pfx, "_act_rd_en"}, 64'(act_rd_en), 64'(0));
        chk({pfx, "_act_addr"},  64'(act_addr),  64'(0));
        chk({pfx, "_act_valid"}, 64'(act_valid), 64'(0));
        chk({pfx, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({pfx, "_out_idx"},   64'(out_idx),   64'(0));
    endtask

    // Runs one job starting in the current cycle (cycle 0). Expected outputs
    // come from the cycle windows of the job timeline. Optionally pulses a
    // second start at cycle 5, or asserts reset during cycle abort_at.
    task automatic run_job(input int base, input int nv, input bit restart5, input int abort_at);
        int s;
        int last;
        int stop;
        logic [ROWS-1:0] ev;
        s    = ROWS + 2;
        last = (nv == 0) ? s : s + ROWS + nv + 1;
        stop = (abort_at >= 0) ? abort_at + 2 : last + 1;
        cw_base = CW_AW'(base);
        num_vec = NV_W'(nv);
        start   = 1'b1;
        for (int c = 1; c <= stop; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (abort_at >= 0 && c > abort_at) begin
                chk_quiet("abort");
`ifdef CPE_CTRL_PERF_EN
                chk("abort_perf_cycles", 64'(perf_cycles), 64'(0));
`endif
                rst_n = 1'b1;
            end else begin
                chk("busy",     64'(busy),     64'(c >= 1 && c <= last));
                chk("done",     64'(done),     64'(c == last));
                chk("cw_rd_en", 64'(cw_rd_en), 64'(c >= 1 && c <= int'(ROWS)));
                if (c >= 1 && c <= int'(ROWS))
                    chk("cw_addr", 64'(cw_addr), 64'((base + int'(ROWS) - c) & 63));
                chk("cw_valid", 64'(cw_valid), 64'(c >= 2 && c <= int'(ROWS) + 1));
                if (c >= 2 && c <= int'(ROWS) + 1)
                    chk("cw_data", 64'(cw_data), 64'(mem[(base + int'(ROWS) + 1 - c) & 63]));
                chk("act_rd_en", 64'(act_rd_en), 64'(c >= s && c < s + nv));
                if (c >= s && c < s + nv)
                    chk("act_addr", 64'(act_addr), 64'(c - s));
                for (int r = 0; r < int'(ROWS); r++)
                    ev[r] = (c >= s + 1 + r) && (c <= s + nv + r);
                chk("act_valid", 64'(act_valid), 64'(ev));
                chk("out_valid", 64'(out_valid),
                    64'(c >= s + 1 + int'(ROWS) && c <= s + int'(ROWS) + nv));
                if (c >= s + 1 + int'(ROWS) && c <= s + int'(ROWS) + nv)
                    chk("out_idx", 64'(out_idx), 64'(c - s - 1 - int'(ROWS)));
                chk("cw_act_excl", 64'(cw_valid && (|act_valid)), 64'(0));
                if (abort_at == c) rst_n = 1'b0;
                if (restart5 && c == 5) begin
                    start   = 1'b1;
                    num_vec = NV_W'(9);
                    cw_base = '0;
                end
            end
        end
        if (abort_at < 0) begin
            for (int r = 0; r < int'(ROWS); r++)
                chk("chain_row", 64'(chain[r]), 64'(mem[(base + r) & 63]));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        num_vec = '0;
        cw_base = '0;
        for (int i = 0; i < 64; i++) mem[i] = 4'($urandom);

        // Reset, then idle with start low
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_quiet("idle");
        end

        // Directed: preload + stream, zero vectors, ignored restart, back-to-back
        run_job(8, 3, 1'b0, -1);
        run_job(8, 0, 1'b0, -1);
        run_job(8, 3, 1'b1, -1);
        run_job(62, 5, 1'b0, -1);

        // Randomized jobs
        for (int j = 0; j < 10; j++) begin
            int b;
            int n;
            b = int'($urandom_range(0, 63));
            n = (j % 3 == 0) ? 0 : int'($urandom_range(1, 20));
            run_job(b, n, 1'($urandom_range(0, 1)), -1);
        end

        // Reset mid-stream, then a fresh job
        run_job(8, 3, 1'b0, 9);
        run_job(int'($urandom_range(0, 63)), int'($urandom_range(1, 12)), 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cpe_column_ctrl.md
Name: cpe_column_ctrl

Overview:
Sequencer for one column of ROWS chained compensation processing elements (CPEs) in the systolic array.
- Preloads 4-bit compensation weights from compensation memory down the CPE weight-pass chain.
- Streams activation vectors with per-row skewed valids.
- Flags the cycles where the column's bottom compensation output holds a finished sum.
- Sits between the compensation memory / activation buffer and the CPE column.

Parameters:
ROWS, 8, number of CPEs in the column (2..64)
CW_AW, 6, compensation-memory address width (2^CW_AW >= ROWS)
ACT_AW, 8, activation-buffer address width
NV_W, 8, width of vector-count field

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begin job (ignored unless IDLE)
num_vec  in  NV_W  activation vectors in job, sampled with start
cw_base  in  CW_AW  compensation-memory base address, sampled with start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at job end
cw_rd_en  out  1  compensation-memory read enable
cw_addr  out  CW_AW  compensation-memory read address
cw_rdata  in  4  read data, valid one cycle after cw_rd_en
cw_data  out  4  weight into row 0 of the chain (= cw_rdata, combinational)
cw_valid  out  1  drives every CPE's weight-out-valid (registered cw_rd_en)
act_rd_en  out  1  activation-buffer read enable
act_addr  out  ACT_AW  activation-buffer address (vector index)
act_valid  out  ROWS  per-row activation valid (bit r for row r)
out_valid  out  1  bottom-row compensation output is a finished sum
out_idx  out  NV_W  vector index of the current out_valid

Behaviour:
- Reset (rst_n=0 at a clock edge) gives:
  - state IDLE.
  - busy, done, cw_rd_en, cw_valid, act_rd_en, act_valid, out_valid all 0.
  - cw_addr, act_addr, out_idx all 0.
  - Applies mid-job too: job aborted, no done pulse.
- States: IDLE -> LOAD_W -> STREAM -> DRAIN -> IDLE. Cycle 0 is the cycle start is sampled in IDLE.
- LOAD_W: cycles 1..ROWS.
  - cw_rd_en=1.
  - cw_addr = cw_base + (ROWS-1-k) at cycle 1+k, so the bottom row's weight is read first.
  - cw_valid=1 at cycles 2..ROWS+1.
  - After the last valid edge, CPE row r holds the word at cw_base+r.
- STREAM: starts at S = ROWS+2; cw_valid=0 from S onward.
  - act_rd_en=1 at cycles S..S+num_vec-1, with act_addr = v at cycle S+v.
  - Leaves for DRAIN after the last read.
- act_valid[r]=1 exactly at cycles S+1+r .. S+num_vec+r (skew of one cycle per row).
- out_valid=1 at cycles S+1+ROWS .. S+ROWS+num_vec, with out_idx = v at cycle S+1+ROWS+v.
- DRAIN: holds until the last out_valid cycle. done=1 at cycle S+ROWS+num_vec+1, state returns to IDLE in the same cycle.
- busy=1 from cycle 1 until done (inclusive).
- num_vec=0: LOAD_W runs normally; no act_rd_en, act_valid or out_valid. done at cycle S, i.e. ROWS+2.
- start while busy: ignored. num_vec and cw_base are not resampled.
- cw_valid and any act_valid bit are never high in the same cycle.
- Arithmetic and wrap rules:
  - cw_addr arithmetic is modulo 2^CW_AW (wraps).
  - act_addr is v zero-extended/truncated to ACT_AW.
  - Skew tracking uses a ROWS-bit shift register fed by the registered act_rd_en: bit0 = act_rd_en delayed 1, bit r = bit r-1 delayed 1.
  - out_valid = bit ROWS-1 delayed 1.

Optional Feature:
CPE_CTRL_PERF_EN
- Defined: adds outputs perf_cycles[15:0] and perf_jobs[15:0].
  - perf_cycles counts cycles with busy=1.
  - perf_jobs counts done pulses.
  - Both saturate at 16'hFFFF and clear only on reset.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> all outputs 0, busy=0 for 10 cycles with start=0.
- Preload, ROWS=4, cw_base=8, num_vec=3:
  - cw_addr = 11,10,9,8 at cycles 1..4; cw_valid at cycles 2..5.
  - Model chain ends with row r = mem[8+r].
- Stream, same job:
  - act_rd_en at cycles 6..8, act_addr 0,1,2.
  - act_valid[0] at 7..9; act_valid[3] at 10..12.
  - out_valid at 11..13 with out_idx 0,1,2; done at cycle 14; busy low at cycle 15.
- Zero vectors, ROWS=4, num_vec=0 -> LOAD_W as above, no act/out activity, done at cycle 6.
- Start while busy: second start at cycle 5 with num_vec=9 -> ignored, job finishes as in the stream scenario; a new start at cycle 15 is accepted.
- Reset mid-stream: rst_n=0 at cycle 9 -> from the next cycle all valids are 0, busy=0, no done pulse. With CPE_CTRL_PERF_EN, perf_cycles=0.
